// File: rtl/mem_port_arbiter_if.sv
// Requester and data-memory signals bundled for the two-port memory arbiter.
// The arbiter takes the slave view; fetch/LSU and memory models take the master view.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 64
);
  logic              req0;
  logic [DATA_W-1:0] addr0;
  logic              we0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic [DATA_W-1:0] addr1;
  logic              we1;
  logic [DATA_W-1:0] wdata1;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;

  modport slave (
    input  req0, addr0, we0, wdata0,
    input  req1, addr1, we1, wdata1,
    input  mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, rdata,
    output gnt0, gnt1, ack0, ack1, err0, err1
  );

  modport master (
    output req0, addr0, we0, wdata0,
    output req1, addr1, we1, wdata1,
    output mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, rdata,
    input  gnt0, gnt1, ack0, ack1, err0, err1
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch (0)
// and load/store (1), holding each grant until memory ack or a cycle timeout.

module mem_port_arbiter_mux2 #(
  parameter int W = 64
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

module mem_port_arbiter #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_last_grant;
  logic               w_next_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [DATA_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_err0;
  logic               r_err1;
  logic               w_grant;
  logic               w_sel;
  logic               w_timeout0;
  logic               w_timeout1;
  logic               w_mux_we;
  logic [DATA_W-1:0]  w_mux_addr;
  logic [DATA_W-1:0]  w_mux_wdata;

  // The grant decision itself selects which requester's fields get captured.
  mem_port_arbiter_mux2 #(.W(DATA_W)) u_mux_addr (
    .i_sel (w_sel),
    .i_a   (bus.addr0),
    .i_b   (bus.addr1),
    .o_y   (w_mux_addr)
  );

  mem_port_arbiter_mux2 #(.W(DATA_W)) u_mux_wdata (
    .i_sel (w_sel),
    .i_a   (bus.wdata0),
    .i_b   (bus.wdata1),
    .o_y   (w_mux_wdata)
  );

  mem_port_arbiter_mux2 #(.W(1)) u_mux_we (
    .i_sel (w_sel),
    .i_a   (bus.we0),
    .i_b   (bus.we1),
    .o_y   (w_mux_we)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last_grant;
    w_grant      = 1'b0;
    w_sel        = 1'b0;
    w_timeout0   = 1'b0;
    w_timeout1   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_grant = 1'b1;
          w_sel   = ~r_last_grant;
        end else if (bus.req0) begin
          w_grant = 1'b1;
          w_sel   = 1'b0;
        end else if (bus.req1) begin
          w_grant = 1'b1;
          w_sel   = 1'b1;
        end
        if (w_grant) begin
          w_next_state = w_sel ? BUSY1 : BUSY0;
        end
      end
      // An ack on the final counted cycle takes priority over the abort.
      BUSY0: begin
        if (bus.mem_ack) begin
          w_next_state = IDLE;
          w_next_last  = 1'b0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_next_state = IDLE;
          w_next_last  = 1'b0;
          w_timeout0   = 1'b1;
        end
      end
      BUSY1: begin
        if (bus.mem_ack) begin
          w_next_state = IDLE;
          w_next_last  = 1'b1;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_next_state = IDLE;
          w_next_last  = 1'b1;
          w_timeout1   = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last;
      r_err0       <= w_timeout0;
      r_err1       <= w_timeout1;
      if (w_grant) begin
        r_cnt   <= '0;
        r_we    <= w_mux_we;
        r_addr  <= w_mux_addr;
        r_wdata <= w_mux_wdata;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.mem_req   = (r_state != IDLE);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.gnt0      = (r_state == BUSY0);
  assign bus.gnt1      = (r_state == BUSY1);
  assign bus.ack0      = bus.mem_ack && (r_state == BUSY0);
  assign bus.ack1      = bus.mem_ack && (r_state == BUSY1);
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues the expected ack/err events,
// an independent monitor pops and compares whenever the arbiter reports a completion.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [3:0]  kind;
    int          busyLen;
    int          gap;
    logic        chkData;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  localparam logic [3:0] K_ACK0 = 4'b0001;
  localparam logic [3:0] K_ACK1 = 4'b0010;
  localparam logic [3:0] K_ERR0 = 4'b0100;
  localparam logic [3:0] K_ERR1 = 4'b1000;

  logic clk = 1'b0;
  logic reset;
  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   stimDone = 1'b0;
  bit   monDone = 1'b0;

  mem_port_arbiter_if #(.DATA_W(64)) bus ();

  mem_port_arbiter #(
    .DATA_W  (64),
    .TIMEOUT (16),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dropReqs();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // One transaction: ackCycle 0 means let it time out; drop/change cycles 0 mean never.
  task automatic applyStimulus(input bit sel, input logic [63:0] addr, input logic we,
                               input logic [63:0] wdata, input int ackCycle,
                               input logic [63:0] rdata, input int dropCycle,
                               input int changeCycle, input int gap);
    exp_t e;
    bit   granted;
    if (ackCycle == 0) e.kind = sel ? K_ERR1 : K_ERR0;
    else               e.kind = sel ? K_ACK1 : K_ACK0;
    e.busyLen = (ackCycle == 0) ? 16 : ackCycle;
    e.gap     = gap;
    e.chkData = (ackCycle != 0);
    e.we      = we;
    e.addr    = addr;
    e.wdata   = wdata;
    e.rdata   = rdata;
    expQ.push_back(e);
    if (sel) begin
      bus.req1 = 1'b1; bus.addr1 = addr; bus.we1 = we; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.addr0 = addr; bus.we0 = we; bus.wdata0 = wdata;
    end
    granted = 1'b0;
    for (int i = 0; i < 8 && !granted; i++) begin
      tick();
      granted = sel ? bus.gnt1 : bus.gnt0;
    end
    for (int c = 1; c <= 40 && granted; c++) begin
      if (c == dropCycle) dropReqs();
      if (c == changeCycle) begin
        if (sel) begin bus.addr1 = 64'h3000; bus.wdata1 = 64'h0BAD; bus.we1 = ~we; end
        else     begin bus.addr0 = 64'h3000; bus.wdata0 = 64'h0BAD; bus.we0 = ~we; end
      end
      if (c == ackCycle) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 64'h0;
      if (!bus.mem_req) break;
    end
    dropReqs();
  endtask

  initial begin : stimulus
    exp_t e;
    int   n;
    reset = 1'b1;
    dropReqs();
    bus.addr0 = '0; bus.we0 = 1'b0; bus.wdata0 = '0;
    bus.addr1 = '0; bus.we1 = 1'b0; bus.wdata1 = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Read by fetch, acked on the third busy cycle.
    applyStimulus(1'b0, 64'h100, 1'b0, 64'h0, 3, 64'hAB, 0, 0, -1);

    // LSU write whose inputs are scrambled mid-transaction.
    applyStimulus(1'b1, 64'h2000, 1'b1, 64'hDEADBEEF, 4, 64'h0, 0, 2, -1);

    // Both requesting with immediate acks: strict alternation 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      e.kind    = (k % 2 == 0) ? K_ACK0 : K_ACK1;
      e.busyLen = 1;
      e.gap     = (k == 0) ? -1 : 1;
      e.chkData = 1'b1;
      e.we      = (k % 2 == 1);
      e.addr    = (k % 2 == 0) ? 64'h1000 : 64'h1008;
      e.wdata   = (k % 2 == 0) ? 64'h44 : 64'h55;
      e.rdata   = 64'h10 + 64'(k);
      expQ.push_back(e);
    end
    bus.addr0 = 64'h1000; bus.we0 = 1'b0; bus.wdata0 = 64'h44;
    bus.addr1 = 64'h1008; bus.we1 = 1'b1; bus.wdata1 = 64'h55;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (bus.gnt0 || bus.gnt1) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'h10 + 64'(n); n++;
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    dropReqs();

    // Timeout with no ack, then ack on the very last counted cycle.
    applyStimulus(1'b0, 64'h400, 1'b0, 64'h0, 0, 64'h0, 0, 0, -1);
    applyStimulus(1'b0, 64'h480, 1'b1, 64'h1234, 16, 64'hC3, 0, 0, -1);

    // Reset in the middle of a requester-1 transaction, stray ack afterwards.
    bus.req1 = 1'b1; bus.addr1 = 64'h500; bus.we1 = 1'b1; bus.wdata1 = 64'h99;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    dropReqs();
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'h77;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick();

    // First tie after reset must go to requester 0.
    e.kind = K_ACK0; e.busyLen = 1; e.gap = -1; e.chkData = 1'b1;
    e.we = 1'b0; e.addr = 64'h700; e.wdata = 64'h0; e.rdata = 64'h5A;
    expQ.push_back(e);
    bus.addr0 = 64'h700; bus.we0 = 1'b0; bus.wdata0 = 64'h0;
    bus.addr1 = 64'h708; bus.we1 = 1'b0; bus.wdata1 = 64'h0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.mem_req) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'h5A;
        break;
      end
    end
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    dropReqs();
    tick();

    // Ack while idle is ignored; a dropped request still completes.
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'hEE;
    tick();
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    applyStimulus(1'b1, 64'h600, 1'b0, 64'h0, 3, 64'h66, 2, 0, -1);
    repeat (3) tick();

    stimDone = 1'b1;
    for (int i = 0; i < 10 && !monDone; i++) @(posedge clk);
    if (!monDone) begin
      $display("[TB] FAIL monitor_done: actual 0 required 1");
      $fatal(1, "[TB] monitor did not finish");
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin : monitor
    exp_t       e;
    logic [3:0] kind;
    int         busyRun;
    int         idleRun;
    int         lastBusy;
    int         gapBefore;
    bit         prevReset;
    busyRun = 0; idleRun = 0; lastBusy = 0; gapBefore = 0; prevReset = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (busyRun == 0) gapBefore = idleRun;
        busyRun++;
        idleRun = 0;
      end else begin
        if (busyRun != 0) lastBusy = busyRun;
        busyRun = 0;
        idleRun++;
      end
      kind = {bus.err1, bus.err0, bus.ack1, bus.ack0};
      checkOutput("exclusive", 64'({bus.gnt0 & bus.gnt1, bus.ack0 & bus.ack1, bus.err0 & bus.err1,
                                    (bus.ack0 | bus.ack1) & (bus.err0 | bus.err1),
                                    (bus.ack0 | bus.ack1) & ~bus.mem_req}), 64'h0);
      if (reset || prevReset) begin
        checkOutput(reset ? "reset_ctrl" : "post_reset_ctrl",
                    64'({bus.mem_req, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1,
                         bus.err0, bus.err1, bus.mem_we}), 64'h0);
        checkOutput("reset_addr", bus.mem_addr, 64'h0);
        checkOutput("reset_wdata", bus.mem_wdata, 64'h0);
      end
      if (kind != 4'b0000) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", 64'(kind), 64'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_kind", 64'(kind), 64'(e.kind));
          if (e.chkData) begin
            checkOutput("busy_cycles", 64'(busyRun), 64'(e.busyLen));
            checkOutput("mem_addr", bus.mem_addr, e.addr);
            checkOutput("mem_we", 64'(bus.mem_we), 64'(e.we));
            checkOutput("mem_wdata", bus.mem_wdata, e.wdata);
            checkOutput("rdata", bus.rdata, e.rdata);
            if (e.gap >= 0) checkOutput("idle_gap", 64'(gapBefore), 64'(e.gap));
          end else begin
            checkOutput("timeout_cycles", 64'(lastBusy), 64'(e.busyLen));
          end
        end
      end
      prevReset = reset;
      if (stimDone && !monDone) begin
        checkOutput("queue_drained", 64'(expQ.size()), 64'h0);
        monDone = 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester round-robin arbiter that shares the single 64-bit data-memory port between instruction fetch (requester 0) and load/store (requester 1). It holds each granted transaction until the memory acknowledges it or a timeout fires. Inside, it uses the codebase's 64-bit 2:1 mux structure to steer address, write data and write enable onto the memory port. It sits between the fetch/LSU stages and the data memory.

Parameters:
DATA_W, 64, width of address, write data and read data
TIMEOUT, 16, max cycles in a BUSY state before abort; legal range 2..255
CNT_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 request, held high until ack0 or err0
addr0  in  DATA_W  requester 0 address
we0  in  1  requester 0 write enable
wdata0  in  DATA_W  requester 0 write data
req1  in  1  requester 1 request
addr1  in  DATA_W  requester 1 address
we1  in  1  requester 1 write enable
wdata1  in  DATA_W  requester 1 write data
mem_ack  in  1  memory completion strobe, 1 cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_req  out  1  memory request, high throughout a BUSY state
mem_we  out  1  captured write enable
mem_addr  out  DATA_W  captured address
mem_wdata  out  DATA_W  captured write data
rdata  out  DATA_W  equals mem_rdata (pass-through)
gnt0  out  1  high while state is BUSY0
gnt1  out  1  high while state is BUSY1
ack0  out  1  mem_ack AND BUSY0 (combinational)
ack1  out  1  mem_ack AND BUSY1 (combinational)
err0  out  1  1-cycle timeout pulse for requester 0 (registered)
err1  out  1  1-cycle timeout pulse for requester 1 (registered)

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, last_grant (1 bit), cnt (CNT_W), capture regs (we, addr, wdata), err0/err1.
- Reset (async, active-high): state=IDLE, last_grant=1 (requester 0 wins the first tie), cnt=0, capture regs=0, err=0. All outputs are 0 during reset and in the first cycle after reset.
- IDLE: no request -> stay. Only req0 -> BUSY0. Only req1 -> BUSY1. Both -> grant the requester that is not last_grant.
- On a grant edge, in the same clock: capture the winner's addr/we/wdata through a 64-bit 2:1 mux whose select is the grant decision, and set cnt=0.
- Grant latency: request seen in IDLE at edge N -> mem_req/gnt high after edge N.
- BUSYx: mem_req=1 and the capture regs are held stable. cnt increments each cycle.
- mem_ack=1 in BUSYx -> ackx=1 in the same cycle. The next state is IDLE, and last_grant=x.
- Timeout: cnt==TIMEOUT-1 with mem_ack=0 -> next state IDLE, errx=1 for exactly one cycle, last_grant=x.
- mem_ack on the timeout cycle: ack wins and no err.
- mem_ack in IDLE is ignored: ack0/ack1 stay 0 and no state change.
- After every completion or abort there is 1 IDLE cycle. Maximum throughput is one transaction per 2 cycles when ack arrives on the first BUSY cycle.
- reqx dropping during BUSYx does not abort. The transaction completes or times out normally.
- Changes on addrx/wdatax/wex during BUSY have no effect on the mem_* outputs.
- Reset mid-transaction: immediate return to IDLE and all outputs 0. Any later mem_ack is ignored.
- gnt0 and gnt1 are never both high. ack0/ack1 and err0/err1 are mutually exclusive, and also exclusive per cycle.

Test Plan:
- Reset then req0=1, addr0=0x100, we0=0; mem_ack on 3rd BUSY cycle with mem_rdata=0xAB -> gnt0 high 3 cycles, ack0=1 with rdata=0xAB, then IDLE.
- req0 and req1 held together, immediate acks -> grants alternate 0,1,0,1; mem_addr alternates addr0/addr1; one IDLE cycle between grants.
- req1=1, we1=1, addr1=0x2000, wdata1=0xDEADBEEF; change addr1 to 0x3000 mid-BUSY -> mem_addr stays 0x2000, mem_we=1, mem_wdata=0xDEADBEEF until ack1.
- req0 with no mem_ack, TIMEOUT=16 -> mem_req high 16 cycles, err0 pulses 1 cycle, then IDLE; a second test with mem_ack on cycle 16 -> ack0=1, err0=0.
- Assert reset during BUSY1, then give mem_ack after release -> all outputs 0, ack1 stays 0, next tie goes to requester 0.
- mem_ack while IDLE and req drop mid-BUSY -> no ack pulse in IDLE; the dropped-req transaction still completes with ackx.
